// File: rtl/mdiv_pkg.sv
// rtl/mdiv_pkg.sv - shared types and constants for the mult/div datapath
`timescale 1ns/1ps
package mdiv_pkg;

    localparam int OPW   = 8;
    localparam int PRODW = 16;
    localparam int ITERS = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mdiv_state_e;

    // Two's-complement magnitude; 0x80 becomes 128, hence the extra bit.
    function automatic logic [OPW:0] mag9(input logic [OPW-1:0] v);
        logic [OPW:0] ext;
        ext = {v[OPW-1], v};
        return v[OPW-1] ? ((OPW+1)'(0) - ext) : ext;
    endfunction

endpackage

// File: rtl/cla_add8.sv
// rtl/cla_add8.sv - 8-bit carry-lookahead adder slice (library cell)
`timescale 1ns/1ps
module cla_add8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] s,
    output logic       cout
);

    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < 8; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
    end

    assign s    = p ^ c[7:0];
    assign cout = c[8];

endmodule

// File: rtl/mult_step8.sv
// rtl/mult_step8.sv - multiplicand gate for one shift-add iteration
`timescale 1ns/1ps
module mult_step8
    import mdiv_pkg::*;
(
    input  logic [OPW-1:0] mcand,
    input  logic           lsb,
    output logic [OPW-1:0] addend
);

    assign addend = lsb ? mcand : '0;

endmodule

// File: rtl/seq_mult8.sv
// rtl/seq_mult8.sv - sequential 8x8 shift-add multiplier; SEQ_MULT8_SIGNED_EN adds signed mode
`timescale 1ns/1ps
module seq_mult8
    import mdiv_pkg::*;
#(
    parameter int EARLY_OUT = 1,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   a,
    input  logic [OPW-1:0]   b,
`ifdef SEQ_MULT8_SIGNED_EN
    input  logic             signed_op,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PRODW-1:0] product,
    output logic             busy
);

    mdiv_state_e      state, state_nxt;
    logic [OPW-1:0]   hi, lo;
    logic [CNT_W-1:0] cnt;
    logic [OPW-1:0]   addend, sum;
    logic             carry;
    logic             zero_op, early;
    logic             last_iter;

`ifdef SEQ_MULT8_SIGNED_EN
    logic [OPW:0]     mcand;
    logic             neg, sgn;
`else
    logic [OPW-1:0]   mcand;
`endif

    mult_step8 u_step (
        .mcand  (mcand[OPW-1:0]),
        .lsb    (lo[0]),
        .addend (addend)
    );

    cla_add8 u_add (
        .a    (hi),
        .b    (addend),
        .cin  (1'b0),
        .s    (sum),
        .cout (carry)
    );

    assign zero_op   = (a == '0) || (b == '0);
    assign early     = (EARLY_OUT != 0) && zero_op;
    assign last_iter = (cnt == CNT_W'(ITERS - 1));

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nxt = early ? DONE : RUN;
            end
            RUN: begin
`ifdef SEQ_MULT8_SIGNED_EN
                if (last_iter) state_nxt = sgn ? FIX : DONE;
`else
                if (last_iter) state_nxt = DONE;
`endif
            end
`ifdef SEQ_MULT8_SIGNED_EN
            FIX: state_nxt = DONE;
`endif
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Only a finished product leaves the block; partial sums stay internal.
    assign product = (state == DONE) ? {hi, lo} : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            hi    <= '0;
            lo    <= '0;
            mcand <= '0;
            cnt   <= '0;
`ifdef SEQ_MULT8_SIGNED_EN
            neg   <= 1'b0;
            sgn   <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        hi  <= '0;
                        cnt <= '0;
`ifdef SEQ_MULT8_SIGNED_EN
                        mcand <= signed_op ? mag9(a) : {1'b0, a};
                        lo    <= early ? '0 : (signed_op ? mag9(b) : {1'b0, b}) >> 0;
                        sgn   <= signed_op && !early;
                        neg   <= signed_op && (a[OPW-1] ^ b[OPW-1]);
`else
                        mcand <= a;
                        lo    <= early ? '0 : b;
`endif
                    end
                end
                RUN: begin
                    // Carry enters at the top so the 9-bit sum is never truncated.
                    {hi, lo} <= {carry, sum, lo[OPW-1:1]};
                    cnt      <= cnt + 1'b1;
                end
`ifdef SEQ_MULT8_SIGNED_EN
                FIX: begin
                    if (neg) {hi, lo} <= PRODW'(0) - {hi, lo};
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult8.sv
// tb/tb_seq_mult8.sv - directed self-checking bench for seq_mult8
`timescale 1ns/1ps
module tb_seq_mult8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_valid2 = 1'b0;
    logic        out_ready = 1'b1;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic        in_ready, out_valid, busy;
    logic [15:0] product;
    logic        in_ready2, out_valid2, busy2;
    logic [15:0] product2;
`ifdef SEQ_MULT8_SIGNED_EN
    logic        signed_op = 1'b0;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    seq_mult8 #(.EARLY_OUT(1), .CNT_W(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef SEQ_MULT8_SIGNED_EN
        .signed_op (signed_op),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    seq_mult8 #(.EARLY_OUT(0), .CNT_W(4)) u_dut_noeo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .a         (a),
        .b         (b),
`ifdef SEQ_MULT8_SIGNED_EN
        .signed_op (1'b0),
`endif
        .out_valid (out_valid2),
        .out_ready (1'b1),
        .product   (product2),
        .busy      (busy2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic sop, input logic eo, input logic [15:0] exp_p);
        int cyc;
        int exp_lat;
        exp_lat = eo ? 1 : (sop ? 10 : 9);
`ifdef SEQ_MULT8_SIGNED_EN
        signed_op = sop;
`endif
        a = av; b = bv; out_ready = 1'b1; in_valid = 1'b1;
        check({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; a = ~av; b = ~bv;
`ifdef SEQ_MULT8_SIGNED_EN
        signed_op = ~sop;
`endif
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            if (cyc == 3) begin a = 8'h77; b = 8'h66; in_valid = 1'b1; end
            @(posedge clk); #1;
            cyc++;
            if (cyc == 4) begin
                check({tag, " in_ready busy"}, {30'd0, busy, in_ready}, 32'd2);
                in_valid = 1'b0;
            end
        end
        check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, " product"}, 32'(product), 32'(exp_p));
        check({tag, " no re-accept"}, 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check({tag, " pulse+idle"}, {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        int  cyc;
        logic stable;

        #2;
        check("reset dut", {13'd0, in_ready, out_valid, busy, product}, {13'd0, 1'b1, 1'b0, 1'b0, 16'h0});
        check("reset noeo", {13'd0, in_ready2, out_valid2, busy2, product2}, {13'd0, 1'b1, 1'b0, 1'b0, 16'h0});
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("d_x_b", 8'h0D, 8'h0B, 1'b0, 1'b0, 16'h008F);
        run_op("ff_ff", 8'hFF, 8'hFF, 1'b0, 1'b0, 16'hFE01);
        run_op("eo_zero", 8'h00, 8'h5A, 1'b0, 1'b1, 16'h0000);
        run_op("80_02", 8'h80, 8'h02, 1'b0, 1'b0, 16'h0100);

        // Same zero operand without early-out takes the full run.
        a = 8'h00; b = 8'h5A; in_valid2 = 1'b1;
        check("noeo in_ready", 32'(in_ready2), 32'd1);
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        cyc = 1;
        while (!out_valid2 && cyc < 40) begin @(posedge clk); #1; cyc++; end
        check("noeo latency", 32'(cyc), 32'd9);
        check("noeo product", 32'(product2), 32'd0);
        @(posedge clk); #1;

        // Back-pressure: result must hold while out_ready is low.
        a = 8'h12; b = 8'h34; out_ready = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 40) begin @(posedge clk); #1; cyc++; end
        check("bp latency", 32'(cyc), 32'd9);
        stable = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            if (!out_valid || product !== 16'h03A8 || in_ready !== 1'b0) stable = 1'b0;
        end
        check("bp hold", 32'(stable), 32'd1);
        check("bp product", 32'(product), 32'h03A8);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp release", {30'd0, out_valid, in_ready}, 32'd1);

        // Asynchronous reset in the middle of RUN.
        a = 8'h12; b = 8'h34; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrun reset", {13'd0, in_ready, out_valid, busy, product}, {13'd0, 1'b1, 1'b0, 1'b0, 16'h0});
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("after_rst", 8'h03, 8'h05, 1'b0, 1'b0, 16'h000F);

`ifdef SEQ_MULT8_SIGNED_EN
        run_op("s_ff_02", 8'hFF, 8'h02, 1'b1, 1'b0, 16'hFFFE);
        run_op("s_80_80", 8'h80, 8'h80, 1'b1, 1'b0, 16'h4000);
        run_op("s_zero", 8'h00, 8'h85, 1'b1, 1'b1, 16'h0000);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_mult8.md
Name: seq_mult8

Overview:
- Sequential 8x8 -> 16-bit shift-add multiplier in the mult/div datapath.
- Each iteration conditionally adds the multiplicand into the upper partial-product byte using the shared 8-bit carry-lookahead adder slice, then shifts right.
- Sits directly upstream of that adder: drives its A, B and cin operands and consumes its S and Cout each cycle.
- Valid/ready handshakes on both the operand side and the result side.

Parameters:
- EARLY_OUT, 1, when 1 a zero operand skips RUN and completes in one cycle.
- CNT_W, 4, width of the iteration counter; must hold the value 8.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands presented.
- in_ready  output  1  block can accept operands.
- a  input  8  multiplicand.
- b  input  8  multiplier.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts product.
- product  output  16  result {hi,lo}.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Clock and reset (fixed):
  - One clock, clk.
  - rst_n is asynchronous and active-low.
- Reset values:
  - State = IDLE, in_ready = 1, out_valid = 0, product = 0, busy = 0.
  - Internal hi, lo, mcand and cnt = 0.
- State IDLE:
  - in_ready = 1.
  - Accept when in_valid && in_ready: mcand <= a, lo <= b, hi <= 0, cnt <= 0.
  - If EARLY_OUT=1 and (a==0 or b==0): go to DONE with product 0.
  - Otherwise go to RUN.
- State RUN:
  - in_ready = 0.
  - Adder inputs: A = hi, B = lo[0] ? mcand : 8'h00, cin = 0.
  - Each cycle: {hi,lo} <= {Cout, S, lo[7:1]}. The 9-bit {Cout,S} shifts in at the top, so the carry is never lost.
  - cnt increments every cycle; after the 8th RUN cycle (cnt==7) go to DONE.
- State DONE:
  - out_valid = 1, product = {hi,lo}.
  - Hold product stable while out_ready = 0.
  - On out_valid && out_ready go to IDLE.
  - No same-cycle re-accept: in_ready first rises the cycle after the handshake.
- Latency:
  - Accept edge to out_valid = 9 cycles (1 cycle on the early-out path).
  - Throughput: one product per 10 cycles minimum.
- Widths:
  - Unsigned arithmetic; product is exact, so overflow is impossible.
  - 0xFF*0xFF = 0xFE01.
- Boundary conditions:
  - in_valid asserted while not in IDLE is ignored; operands are not latched and in_ready stays 0.
  - Operand changes after acceptance have no effect.
  - rst_n asserted mid-RUN or mid-DONE:
    - Immediate return to reset values.
    - A partial product is never presented.
    - A pending out_valid is dropped.
  - cnt never wraps; the RUN exit is decoded at cnt==7.

Optional Feature:
- Macro: SEQ_MULT8_SIGNED_EN.
- When defined:
  - Adds input port signed_op (1 bit), sampled on accept.
  - If signed_op=1, both operands are taken as two's complement. Their magnitudes are latched: 0x80 maps to 128 and is held in a 9-bit magnitude, so mcand is widened to 9 bits internally.
  - neg = a[7]^b[7] is recorded.
  - After RUN, an extra FIX state negates {hi,lo} when neg = 1. Signed latency = 10 cycles.
  - Early-out yields 0 with no FIX state.
- When undefined:
  - No signed_op port and no FIX state.
  - Purely unsigned, latency 9.

Decomposition:
- Shared package mdiv_pkg:
  - State enum: IDLE, RUN, FIX, DONE.
  - Constants OPW=8, PRODW=16, ITERS=8.
- One natural sub-module: mult_step8, the combinational operand select (lo[0] ? mcand : 0) feeding the carry-lookahead adder. The adder itself is instantiated unchanged from the existing library cell.
- Control FSM and registers stay in seq_mult8.

Test Plan:
- a=0x0D, b=0x0B, out_ready=1 -> product=0x008F; out_valid exactly 9 cycles after accept, high for 1 cycle.
- a=0xFF, b=0xFF -> product=0xFE01. Checks that the carry out of the adder is retained through the shift on every iteration.
- EARLY_OUT=1, a=0x00, b=0x5A -> product=0x0000 one cycle after accept. With EARLY_OUT=0 the result is the same but arrives at 9 cycles.
- a=0x12, b=0x34, out_ready held low 5 cycles -> out_valid and product=0x03A8 held stable; in_ready stays 0 until the cycle after the handshake.
- rst_n pulsed low at RUN cycle 4 -> all outputs at reset values asynchronously. The next op, a=0x03, b=0x05, gives 0x000F with normal latency.
- SEQ_MULT8_SIGNED_EN, signed_op=1:
  - a=0xFF, b=0x02 -> 0xFFFE at 10 cycles.
  - a=0x80, b=0x80 -> 0x4000.
